axis_out_packer: RTL and testbench

AXIS_OUT_PACKER -- requirements
Module: axis_out_packer

---
 rtl/axis_out_packer_pkg.sv | 19 +
 rtl/axis_out_packer.sv | 152 +++++++++++++++
 tb/tb_axis_out_packer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_out_packer_pkg.sv
// Shared parameters, state encoding and helpers for the AXI-Stream output packer.
package axis_out_packer_pkg;

  localparam int unsigned ROWS           = 8;
  localparam int unsigned COLS           = 24;
  localparam int unsigned WORD_WIDTH_ACC = 32;
  localparam int unsigned TUSER_WIDTH    = 8;
  localparam int unsigned I_IS_CONFIG    = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/axis_out_packer.sv
// Serialises one wide PE-array result beat into M_WORDS-wide AXI-Stream beats.
// Optional performance counters are enabled with AXIS_OUT_PACKER_PERF_EN.
module axis_out_packer #(
  parameter int unsigned ROWS           = axis_out_packer_pkg::ROWS,
  parameter int unsigned COLS           = axis_out_packer_pkg::COLS,
  parameter int unsigned WORD_WIDTH_ACC = axis_out_packer_pkg::WORD_WIDTH_ACC,
  parameter int unsigned M_WORDS        = 4,
  parameter int unsigned TUSER_WIDTH    = axis_out_packer_pkg::TUSER_WIDTH,
  parameter int unsigned I_IS_CONFIG    = axis_out_packer_pkg::I_IS_CONFIG
) (
  input  logic                                aclk,
  input  logic                                rst,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic                                s_last,
  input  logic [TUSER_WIDTH-1:0]              s_user,
  input  logic [ROWS*COLS*WORD_WIDTH_ACC-1:0] s_data,
  input  logic [$clog2(COLS+1)-1:0]           cfg_cols,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic                                m_last,
  output logic [TUSER_WIDTH-1:0]              m_user,
  output logic [M_WORDS*WORD_WIDTH_ACC-1:0]   m_data,
  output logic [M_WORDS-1:0]                  m_keep
`ifdef AXIS_OUT_PACKER_PERF_EN
  ,
  output logic [31:0]                         perf_beats,
  output logic [15:0]                         perf_cfg_drops
`endif
);
  import axis_out_packer_pkg::*;

  localparam int unsigned N_WORDS   = ROWS * COLS;
  localparam int unsigned W         = WORD_WIDTH_ACC;
  localparam int unsigned NB_MAX    = ceil_div(N_WORDS, M_WORDS);
  localparam int unsigned BEAT_W    = M_WORDS * W;
  localparam int unsigned SREG_W    = NB_MAX * M_WORDS * W;
  localparam int unsigned NW_W      = $clog2(N_WORDS + 1);
  localparam int unsigned CNT_W     = $clog2(NB_MAX + 1);
  localparam int unsigned CC_W      = $clog2(COLS + 1);

  state_e                  state_q, state_d;
  logic [SREG_W-1:0]       sreg_q;
  logic [TUSER_WIDTH-1:0]  user_q;
  logic                    last_q;
  logic [NW_W-1:0]         nw_q;
  logic [CNT_W-1:0]        nb_q;
  logic [CNT_W-1:0]        beat_cnt_q;

  logic                    load, adv, take, final_beat;
  logic [CC_W-1:0]         eff_cols;
  logic [NW_W-1:0]         nw_c;
  logic [CNT_W-1:0]        nb_c;

  // Out-of-range or zero column counts fall back to the full array
  assign eff_cols   = (cfg_cols == '0 || 32'(cfg_cols) > COLS) ? CC_W'(COLS) : cfg_cols;
  assign nw_c       = NW_W'(ROWS * 32'(eff_cols));
  assign nb_c       = CNT_W'(ceil_div(ROWS * 32'(eff_cols), M_WORDS));
  assign final_beat = (beat_cnt_q == CNT_W'(nb_q - CNT_W'(1)));

  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    load    = 1'b0;
    adv     = 1'b0;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        s_ready = ~rst;
        take    = s_valid & ~rst;
        if (take && !s_user[I_IS_CONFIG]) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        s_ready = final_beat & m_ready & ~rst;
        take    = s_valid & final_beat & m_ready & ~rst;
        if (m_ready) begin
          if (!final_beat) begin
            adv = 1'b1;
          end else if (take && !s_user[I_IS_CONFIG]) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      user_q     <= '0;
      last_q     <= 1'b0;
      nw_q       <= '0;
      nb_q       <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        sreg_q     <= SREG_W'(s_data);
        user_q     <= s_user;
        last_q     <= s_last;
        nw_q       <= nw_c;
        nb_q       <= nb_c;
        beat_cnt_q <= '0;
      end else if (adv) begin
        sreg_q     <= sreg_q >> BEAT_W;
        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
      end
    end
  end

  assign m_valid = (state_q == SHIFT);
  assign m_user  = user_q;
  assign m_last  = m_valid & final_beat & last_q;

  // Words past the active count are masked to zero
  always_comb begin
    m_keep = '0;
    m_data = '0;
    for (int unsigned k = 0; k < M_WORDS; k++) begin
      if (m_valid && (32'(beat_cnt_q) * M_WORDS + k) < 32'(nw_q)) begin
        m_keep[k]        = 1'b1;
        m_data[k*W +: W] = sreg_q[k*W +: W];
      end
    end
  end

`ifdef AXIS_OUT_PACKER_PERF_EN
  logic cfg_drop;
  assign cfg_drop = take & s_user[I_IS_CONFIG];

  // Saturating event counters
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      perf_beats     <= '0;
      perf_cfg_drops <= '0;
    end else begin
      if (m_valid && m_ready && perf_beats != '1)
        perf_beats <= perf_beats + 32'd1;
      if (cfg_drop && perf_cfg_drops != '1)
        perf_cfg_drops <= perf_cfg_drops + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_out_packer.sv
// Scoreboard bench for axis_out_packer: instance 0 uses M_WORDS=4, instance 1 uses M_WORDS=5.
module tb_axis_out_packer;

  localparam int unsigned R      = 4;
  localparam int unsigned C      = 4;
  localparam int unsigned W      = 32;
  localparam int unsigned U      = 8;
  localparam int unsigned NWORDS = R * C;
  localparam int unsigned DW     = NWORDS * W;
  localparam int unsigned CCW    = $clog2(C + 1);
  localparam int unsigned XW     = 5 * W;

  typedef struct {
    logic [XW-1:0] data;
    logic [4:0]    keep;
    logic [U-1:0]  user;
    logic          last;
  } exp_t;
  typedef logic [W-1:0] word_arr_t [NWORDS];

  logic aclk = 1'b0;
  logic rst  = 1'b1;
  always #5 aclk = ~aclk;

  logic           s_valid0 = 1'b0, s_ready0, s_last0 = 1'b0;
  logic [U-1:0]   s_user0 = '0;
  logic [DW-1:0]  s_data0 = '0;
  logic [CCW-1:0] cfg_cols0 = '0;
  logic           m_valid0, m_ready0 = 1'b0, m_last0;
  logic [U-1:0]   m_user0;
  logic [4*W-1:0] m_data0;
  logic [3:0]     m_keep0;

  logic           s_valid1 = 1'b0, s_ready1, s_last1 = 1'b0;
  logic [U-1:0]   s_user1 = '0;
  logic [DW-1:0]  s_data1 = '0;
  logic [CCW-1:0] cfg_cols1 = '0;
  logic           m_valid1, m_ready1 = 1'b0, m_last1;
  logic [U-1:0]   m_user1;
  logic [5*W-1:0] m_data1;
  logic [4:0]     m_keep1;

`ifdef AXIS_OUT_PACKER_PERF_EN
  logic [31:0] perf_beats0, perf_beats1;
  logic [15:0] perf_cfg_drops0, perf_cfg_drops1;
`endif

  axis_out_packer #(.ROWS(R), .COLS(C), .WORD_WIDTH_ACC(W), .M_WORDS(4),
                    .TUSER_WIDTH(U), .I_IS_CONFIG(0)) u_dut0 (
    .aclk(aclk), .rst(rst),
    .s_valid(s_valid0), .s_ready(s_ready0), .s_last(s_last0), .s_user(s_user0),
    .s_data(s_data0), .cfg_cols(cfg_cols0),
    .m_valid(m_valid0), .m_ready(m_ready0), .m_last(m_last0), .m_user(m_user0),
    .m_data(m_data0), .m_keep(m_keep0)
`ifdef AXIS_OUT_PACKER_PERF_EN
    , .perf_beats(perf_beats0), .perf_cfg_drops(perf_cfg_drops0)
`endif
  );

  axis_out_packer #(.ROWS(R), .COLS(C), .WORD_WIDTH_ACC(W), .M_WORDS(5),
                    .TUSER_WIDTH(U), .I_IS_CONFIG(0)) u_dut1 (
    .aclk(aclk), .rst(rst),
    .s_valid(s_valid1), .s_ready(s_ready1), .s_last(s_last1), .s_user(s_user1),
    .s_data(s_data1), .cfg_cols(cfg_cols1),
    .m_valid(m_valid1), .m_ready(m_ready1), .m_last(m_last1), .m_user(m_user1),
    .m_data(m_data1), .m_keep(m_keep1)
`ifdef AXIS_OUT_PACKER_PERF_EN
    , .perf_beats(perf_beats1), .perf_cfg_drops(perf_cfg_drops1)
`endif
  );

  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   pct0 = 100, pct1 = 100;
  int   beats0 = 0, beats1 = 0;
  int   beats0_rst = 0;
  int   drops_exp = 0;

  // Reference: the beat stream one input beat should produce
  function automatic void model(input int inst, input word_arr_t wd, input int cc,
                                input logic [U-1:0] user, input logic last);
    int m, eff, nw, nb, idx;
    m   = (inst == 0) ? 4 : 5;
    eff = (cc == 0 || cc > int'(C)) ? int'(C) : cc;
    nw  = int'(R) * eff;
    nb  = (nw + m - 1) / m;
    for (int b = 0; b < nb; b++) begin
      exp_t e;
      e.data = '0;
      e.keep = '0;
      e.user = user;
      e.last = last && (b == nb - 1);
      for (int k = 0; k < m; k++) begin
        idx = b * m + k;
        if (idx < nw) begin
          e.keep[k]        = 1'b1;
          e.data[k*W +: W] = wd[idx];
        end
      end
      if (inst == 0) q0.push_back(e);
      else           q1.push_back(e);
    end
  endfunction

  function automatic word_arr_t seq_words(input int base);
    word_arr_t w;
    for (int k = 0; k < int'(NWORDS); k++) w[k] = W'(base + k);
    return w;
  endfunction

  function automatic word_arr_t rand_words();
    word_arr_t w;
    for (int k = 0; k < int'(NWORDS); k++) w[k] = $urandom;
    return w;
  endfunction

  initial forever begin
    @(posedge aclk); #1;
    m_ready0 = ($urandom_range(99, 0) < pct0);
    m_ready1 = ($urandom_range(99, 0) < pct1);
  end

  // Monitor for instance 0
  initial begin
    logic stall;
    logic [4*W-1:0] pd;
    logic [3:0] pk;
    logic [U-1:0] pu;
    logic pl;
    exp_t e;
    stall = 1'b0;
    forever begin
      @(negedge aclk);
      if (rst) begin
        stall = 1'b0;
        beats0_rst = 0;
      end else begin
        if (stall) begin
          checks++;
          if (!m_valid0 || m_data0 !== pd || m_keep0 !== pk || m_user0 !== pu || m_last0 !== pl) begin
            errors++;
            $display("FAIL stable0 valid=%b data=%h keep=%b user=%h last=%b required held data=%h keep=%b user=%h last=%b",
                     m_valid0, m_data0, m_keep0, m_user0, m_last0, pd, pk, pu, pl);
          end
        end
        if (m_valid0 && m_ready0) begin
          beats0++;
          beats0_rst++;
          checks++;
          if (q0.size() == 0) begin
            errors++;
            $display("FAIL extra0 unexpected beat data=%h keep=%b", m_data0, m_keep0);
          end else begin
            e = q0.pop_front();
            if (m_data0 !== e.data[4*W-1:0] || m_keep0 !== e.keep[3:0] ||
                m_user0 !== e.user || m_last0 !== e.last) begin
              errors++;
              $display("FAIL beat0 data=%h keep=%b user=%h last=%b required data=%h keep=%b user=%h last=%b",
                       m_data0, m_keep0, m_user0, m_last0, e.data[4*W-1:0], e.keep[3:0], e.user, e.last);
            end
          end
        end
        stall = m_valid0 && !m_ready0;
        pd = m_data0; pk = m_keep0; pu = m_user0; pl = m_last0;
      end
    end
  end

  // Monitor for instance 1
  initial begin
    logic stall;
    logic [5*W-1:0] pd;
    logic [4:0] pk;
    logic [U-1:0] pu;
    logic pl;
    exp_t e;
    stall = 1'b0;
    forever begin
      @(negedge aclk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          checks++;
          if (!m_valid1 || m_data1 !== pd || m_keep1 !== pk || m_user1 !== pu || m_last1 !== pl) begin
            errors++;
            $display("FAIL stable1 valid=%b data=%h keep=%b user=%h last=%b required held data=%h keep=%b user=%h last=%b",
                     m_valid1, m_data1, m_keep1, m_user1, m_last1, pd, pk, pu, pl);
          end
        end
        if (m_valid1 && m_ready1) begin
          beats1++;
          checks++;
          if (q1.size() == 0) begin
            errors++;
            $display("FAIL extra1 unexpected beat data=%h keep=%b", m_data1, m_keep1);
          end else begin
            e = q1.pop_front();
            if (m_data1 !== e.data || m_keep1 !== e.keep || m_user1 !== e.user || m_last1 !== e.last) begin
              errors++;
              $display("FAIL beat1 data=%h keep=%b user=%h last=%b required data=%h keep=%b user=%h last=%b",
                       m_data1, m_keep1, m_user1, m_last1, e.data, e.keep, e.user, e.last);
            end
          end
        end
        stall = m_valid1 && !m_ready1;
        pd = m_data1; pk = m_keep1; pu = m_user1; pl = m_last1;
      end
    end
  end

  // Issues one input beat; caller and return are both at posedge+1
  task automatic send(input int inst, input word_arr_t wd, input int cc,
                      input logic [U-1:0] user, input logic last);
    logic [DW-1:0] d;
    logic rdy;
    for (int k = 0; k < int'(NWORDS); k++) d[k*W +: W] = wd[k];
    if (inst == 0) begin
      s_data0 = d; s_user0 = user; s_last0 = last; cfg_cols0 = CCW'(cc); s_valid0 = 1'b1;
    end else begin
      s_data1 = d; s_user1 = user; s_last1 = last; cfg_cols1 = CCW'(cc); s_valid1 = 1'b1;
    end
    for (int t = 0; t < 400; t++) begin
      @(negedge aclk);
      rdy = (inst == 0) ? s_ready0 : s_ready1;
      if (rdy) begin
        if (!user[0]) model(inst, wd, cc, user, last);
        else if (inst == 0) drops_exp++;
        @(posedge aclk); #1;
        if (inst == 0) begin s_valid0 = 1'b0; cfg_cols0 = CCW'($urandom_range(7, 0)); end
        else           begin s_valid1 = 1'b0; cfg_cols1 = CCW'($urandom_range(7, 0)); end
        return;
      end
    end
    checks++; errors++;
    $display("FAIL handshake%0d timeout waiting for s_ready", inst);
    if (inst == 0) s_valid0 = 1'b0; else s_valid1 = 1'b0;
  endtask

  task automatic drain(input int inst);
    for (int t = 0; t < 2000; t++) begin
      @(negedge aclk);
      if (inst == 0 && q0.size() == 0 && !m_valid0) begin @(posedge aclk); #1; return; end
      if (inst == 1 && q1.size() == 0 && !m_valid1) begin @(posedge aclk); #1; return; end
    end
    checks++; errors++;
    $display("FAIL drain%0d timeout, pending=%0d", inst, (inst == 0) ? q0.size() : q1.size());
    @(posedge aclk); #1;
  endtask

  task automatic check_cnt(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask

  initial begin
    int b;
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    // Reset state
    repeat (2) @(negedge aclk);
    check_cnt("rst_s_ready0", int'(s_ready0), 0);
    check_cnt("rst_s_ready1", int'(s_ready1), 0);
    checks++;
    if (m_valid0 || m_last0 || m_keep0 !== '0 || m_data0 !== '0 || m_user0 !== '0) begin
      errors++;
      $display("FAIL rst_outs0 valid=%b last=%b keep=%b data=%h user=%h required all zero",
               m_valid0, m_last0, m_keep0, m_data0, m_user0);
    end
    rst = 1'b0;
    @(negedge aclk);
    check_cnt("post_rst_s_ready0", int'(s_ready0), 1);
`ifdef AXIS_OUT_PACKER_PERF_EN
    check_cnt("rst_perf_beats", int'(perf_beats0), 0);
    check_cnt("rst_perf_drops", int'(perf_cfg_drops0), 0);
`endif
    @(posedge aclk); #1;

    // Full array, partial columns and the zero-columns fallback
    pct0 = 100;
    b0 = beats0; send(0, seq_words(0), 4, 8'h20, 1'b1); drain(0);
    check_cnt("nbeats_cols4", beats0 - b0, 4);
    b0 = beats0; send(0, seq_words(0), 3, 8'h40, 1'b1); drain(0);
    check_cnt("nbeats_cols3", beats0 - b0, 3);
    b0 = beats0; send(0, seq_words(0), 0, 8'h42, 1'b1); drain(0);
    check_cnt("nbeats_cols0", beats0 - b0, 4);

    // Five words per beat leaves a single-word tail
    pct1 = 100;
    b0 = beats1; send(1, seq_words(0), 4, 8'h10, 1'b1); drain(1);
    check_cnt("nbeats_m5", beats1 - b0, 4);

    // Config beat dropped, then a data beat
    b0 = beats0;
    send(0, seq_words(100), 4, 8'h01, 1'b1);
    send(0, seq_words(200), 4, 8'h02, 1'b0);
    drain(0);
    check_cnt("nbeats_after_cfg", beats0 - b0, 4);
`ifdef AXIS_OUT_PACKER_PERF_EN
    check_cnt("perf_cfg_drops", int'(perf_cfg_drops0), 1);
`endif

    // Back-to-back beats under 30% ready
    pct0 = 30;
    b0 = beats0;
`ifdef AXIS_OUT_PACKER_PERF_EN
    b = int'(perf_beats0);
`endif
    send(0, seq_words(300), 4, 8'h06, 1'b1);
    send(0, seq_words(400), 4, 8'h08, 1'b1);
    drain(0);
    check_cnt("nbeats_b2b", beats0 - b0, 8);
`ifdef AXIS_OUT_PACKER_PERF_EN
    check_cnt("perf_beats_b2b", int'(perf_beats0) - b, 8);
`endif

    // Randomised traffic on both widths
    for (int i = 0; i < 40; i++) begin
      logic [U-1:0] u;
      u = U'($urandom);
      u[0] = ($urandom_range(3, 0) == 0);
      case ($urandom_range(2, 0))
        0: pct0 = 30;
        1: pct0 = 70;
        default: pct0 = 100;
      endcase
      send(0, rand_words(), int'($urandom_range(7, 0)), u, 1'($urandom));
      repeat ($urandom_range(2, 0)) begin @(posedge aclk); #1; end
    end
    drain(0);
    for (int i = 0; i < 15; i++) begin
      logic [U-1:0] u;
      u = U'($urandom);
      u[0] = ($urandom_range(3, 0) == 0);
      pct1 = int'($urandom_range(100, 30));
      send(1, rand_words(), int'($urandom_range(7, 0)), u, 1'($urandom));
    end
    drain(1);
`ifdef AXIS_OUT_PACKER_PERF_EN
    check_cnt("perf_beats_total", int'(perf_beats0), beats0_rst);
    check_cnt("perf_drops_total", int'(perf_cfg_drops0), drops_exp);
`endif

    // Reset while the second of four output beats is presented
    pct0 = 100;
    send(0, seq_words(500), 4, 8'h30, 1'b1);
    @(posedge aclk); #1;
    rst = 1'b1;
    #1;
    check_cnt("rst_midbeat_m_valid", int'(m_valid0), 0);
    check_cnt("rst_midbeat_s_ready", int'(s_ready0), 0);
    q0.delete();
    drops_exp = 0;
    repeat (2) begin @(posedge aclk); #1; end
    rst = 1'b0;
    @(negedge aclk);
    check_cnt("rel_s_ready", int'(s_ready0), 1);
    check_cnt("rel_m_valid", int'(m_valid0), 0);
    @(posedge aclk); #1;
    b0 = beats0;
    send(0, seq_words(600), 4, 8'h32, 1'b1);
    drain(0);
    check_cnt("nbeats_after_rst", beats0 - b0, 4);
`ifdef AXIS_OUT_PACKER_PERF_EN
    check_cnt("perf_beats_after_rst", int'(perf_beats0), 4);
    check_cnt("perf_drops_after_rst", int'(perf_cfg_drops0), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
